// File: rtl/mult_seq_param.sv
// Sequential shift-add multiplier, one multiplier bit per clock, with a
// per-operation signed mode handled as sign-magnitude around an unsigned core.
module mult_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     a_bi,
    input  logic [WIDTH-1:0]     b_bi,
    input  logic                 signed_i,
    input  logic                 start,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   y_bo
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, WORK} state_t;

    state_t            state_q;
    logic [PW-1:0]     mcand_q;
    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     y_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [CW-1:0]     cnt_q;
    logic              neg_q;
    logic              busy_q;
    logic              done_q;

    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [PW-1:0]     addend;
    logic [PW-1:0]     acc_d;

    // The most-negative operand negates to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        a_mag = (signed_i && a_bi[WIDTH-1]) ? -a_bi : a_bi;
        b_mag = (signed_i && b_bi[WIDTH-1]) ? -b_bi : b_bi;
    end

    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_addend
            assign addend[gi] = mcand_q[gi] & mplier_q[0];
        end
    endgenerate

    always_comb begin
        acc_d = acc_q + addend;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            y_q      <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, a_mag};
                        mplier_q <= b_mag;
                        neg_q    <= signed_i & (a_bi[WIDTH-1] ^ b_bi[WIDTH-1]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= WORK;
                    end
                end
                WORK: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        y_q     <= neg_q ? -acc_d : acc_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign y_bo   = y_q;

endmodule

// File: doc/mult_seq_param.md
Name: mult_seq_param

Overview:
Parametrised sequential shift-add multiplier that succeeds the fixed 8-bit `mult`. It keeps the start/busy handshake and the `a_bi`/`b_bi`/`y_bo` naming, and adds three things:
- a WIDTH parameter;
- a per-operation signed/unsigned mode;
- a one-cycle done strobe.

It processes one multiplier bit per clock. It is a shared multiply resource for the arithmetic datapath blocks.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..32); the result is 2*WIDTH bits.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
a_bi  input  WIDTH  multiplicand; sampled only on the accept edge
b_bi  input  WIDTH  multiplier; sampled only on the accept edge
signed_i  input  1  1 = operands and result are two's complement; sampled on the accept edge
start  input  1  request a multiply; honoured only when busy_o=0
busy_o  output  1  high while an operation is in progress
done_o  output  1  one-cycle pulse on the cycle the result becomes valid
y_bo  output  2*WIDTH  product; holds the last completed result until the next completion

Behaviour:
- Reset (reset=1 at a rising edge, regardless of state):
  - state := IDLE; busy_o=0, done_o=0, y_bo=0.
  - All internal registers are cleared.
  - reset takes priority over start.
  - A reset mid-operation aborts it; no done_o is produced and y_bo reads 0.
- States:
  - IDLE: busy_o=0.
  - WORK: busy_o=1, bit counter cnt runs 0..WIDTH-1.
- Accept edge: in IDLE with start=1, the block:
  - latches the operand magnitudes: |a|, |b| when signed_i=1, raw values otherwise;
  - latches the result sign: a[MSB] XOR b[MSB] when signed_i=1, else 0;
  - clears the accumulator and sets cnt=0;
  - goes to WORK.
  - busy_o is 1 from the cycle after the accept edge.
- Magnitude of the most-negative value (e.g. -128 for WIDTH=8) is 2^(WIDTH-1). It is held as an unsigned WIDTH-bit value; no overflow is possible.
- WORK, each edge:
  - if the multiplier LSB is 1, add the multiplicand (zero-extended to 2*WIDTH, shifted left by cnt) to the 2*WIDTH-bit accumulator;
  - shift the multiplier right by 1 and increment cnt.
- Completion edge (cnt=WIDTH-1):
  - the final partial product is included;
  - y_bo := sign ? -(acc) mod 2^(2*WIDTH) : acc;
  - busy_o := 0, done_o := 1 for exactly this one cycle, state := IDLE.
- Latency:
  - the result is visible WIDTH rising edges after the accept edge; busy_o is high for exactly WIDTH cycles;
  - the next start can be accepted on the cycle where done_o=1, i.e. back-to-back throughput is one operation per WIDTH+1 cycles.
- Width and overflow:
  - unsigned results are in 0..(2^WIDTH-1)^2 and always fit in 2*WIDTH bits;
  - signed results are in -2^(2W-2)+2^(W-1)..2^(2W-2) and fit in a 2*WIDTH-bit two's complement value;
  - no overflow flag exists.
- Zero operand: there is no early termination; latency stays WIDTH cycles. A zero product is never negated to a nonzero value (-0 = 0).
- Input changes:
  - start asserted while busy_o=1 is ignored; it is not queued.
  - a_bi, b_bi and signed_i may change freely after the accept edge without affecting the result.
- done_o is 0 in every cycle except the completion cycle; y_bo changes only on the completion edge or on reset.

Test Plan:
- WIDTH=8, reset 1 cycle, then start=1 for one cycle with a=b=8, signed_i=0 → busy_o=1 for 8 cycles; y_bo=16'd64 with done_o=1 for one cycle; afterwards y_bo holds 64 and busy_o=0.
- WIDTH=8, unsigned 255*255 → 16'hFE01 (65025); then start on the done_o cycle with a=0, b=200 → accepted immediately, result 0 after 8 more cycles.
- WIDTH=8, signed_i=1:
  - -3*5 → 16'hFFF1;
  - -128*-128 → 16'h4000;
  - -128*127 → 16'hC080;
  - 0*-1 → 16'h0000.
- WIDTH=8: start 3*4; after 2 cycles pulse start again with 9*9 → second request ignored; result 16'd12; busy_o high exactly 8 cycles; only one done_o pulse.
- WIDTH=8: start 100*100, assert reset on cycle 4 of WORK → next cycle busy_o=0, y_bo=0; done_o never pulses; a new 2*3 then yields 6.
- WIDTH=4 instance:
  - unsigned 15*15 → 8'hE1, latency 4 cycles;
  - signed -8*7 → 8'hC8;
  - signed -8*-8 → 8'h40.
